axis_input_join: RTL and testbench

AXIS_INPUT_JOIN -- requirements
Module: axis_input_join

---
 rtl/axis_join_pkg.sv | 12 +
 rtl/axis_skid_fifo.sv | 54 +++++
 rtl/axis_input_join.sv | 146 ++++++++++++++
 tb/tb_axis_input_join.sv | 314 +++++++++++++++++++++++++++++++
 4 files changed

// File: rtl/axis_join_pkg.sv
// Shared types and constants for the AXI-stream input join.
package axis_join_pkg;

    localparam int FIFO_DEPTH = 2;

    typedef enum logic [1:0] {
        ST_IDLE  = 2'd0,
        ST_RUN   = 2'd1,
        ST_FLUSH = 2'd2
    } join_state_t;

endpackage

// File: rtl/axis_skid_fifo.sv
// Small per-channel input buffer carrying {tlast, tdata}; depth comes from the package.
module axis_skid_fifo
    import axis_join_pkg::*;
#(
    parameter int WIDTH = 33
) (
    input  logic             i_clk,
    input  logic             i_rst_n,
    input  logic             i_wr_en,
    input  logic [WIDTH-1:0] i_wr_data,
    input  logic             i_rd_en,
    output logic [WIDTH-1:0] o_rd_data,
    output logic             o_full,
    output logic             o_empty
);

    localparam int AW = (FIFO_DEPTH > 1) ? $clog2(FIFO_DEPTH) : 1;
    localparam int CW = $clog2(FIFO_DEPTH + 1);

    logic [WIDTH-1:0] r_mem [FIFO_DEPTH];
    logic [AW-1:0]    r_wptr;
    logic [AW-1:0]    r_rptr;
    logic [CW-1:0]    r_count;
    logic             w_push;
    logic             w_pop;

    function automatic logic [AW-1:0] ptr_inc(input logic [AW-1:0] p);
        return (p == AW'(FIFO_DEPTH - 1)) ? '0 : p + 1'b1;
    endfunction

    assign o_full    = (r_count == CW'(FIFO_DEPTH));
    assign o_empty   = (r_count == '0);
    assign w_push    = i_wr_en && !o_full;
    assign w_pop     = i_rd_en && !o_empty;
    assign o_rd_data = r_mem[r_rptr];

    always_ff @(posedge i_clk or negedge i_rst_n) begin
        if (!i_rst_n) begin
            r_wptr  <= '0;
            r_rptr  <= '0;
            r_count <= '0;
            for (int i = 0; i < FIFO_DEPTH; i++) r_mem[i] <= '0;
        end else begin
            if (w_push) begin
                r_mem[r_wptr] <= i_wr_data;
                r_wptr        <= ptr_inc(r_wptr);
            end
            if (w_pop) r_rptr <= ptr_inc(r_rptr);
            if (w_push && !w_pop)      r_count <= r_count + 1'b1;
            else if (w_pop && !w_push) r_count <= r_count - 1'b1;
        end
    end

endmodule

// File: rtl/axis_input_join.sv
// Joins N_CH AXI-stream inputs into one beat per cycle under a per-packet channel mask,
// flushing the longer channels when their tlasts disagree.
module axis_input_join
    import axis_join_pkg::*;
#(
    parameter int N_CH       = 3,
    parameter int WORD_WIDTH = 8,
    parameter int WORDS      = 4,
    parameter int CNT_WIDTH  = 16
) (
    input  logic                              aclk,
    input  logic                              aresetn,
    input  logic [N_CH-1:0]                   ch_enable,
    input  logic [N_CH*WORD_WIDTH*WORDS-1:0]  s_axis_tdata,
    input  logic [N_CH-1:0]                   s_axis_tvalid,
    output logic [N_CH-1:0]                   s_axis_tready,
    input  logic [N_CH-1:0]                   s_axis_tlast,
    output logic [N_CH*WORD_WIDTH*WORDS-1:0]  m_axis_tdata,
    output logic                              m_axis_tvalid,
    input  logic                              m_axis_tready,
    output logic                              m_axis_tlast,
    output logic                              err_tlast_mismatch,
    output logic [CNT_WIDTH-1:0]              packet_count
);

    localparam int DW = WORD_WIDTH * WORDS;

    join_state_t              r_state;
    logic [N_CH-1:0]          r_mask;
    logic [N_CH-1:0]          r_held;
    logic                     r_tvalid;
    logic                     r_tlast;
    logic [N_CH*DW-1:0]       r_tdata;
    logic                     r_err;
    logic [CNT_WIDTH-1:0]     r_count;

    logic [N_CH-1:0]          w_full;
    logic [N_CH-1:0]          w_empty;
    logic [N_CH-1:0]          w_push;
    logic [N_CH-1:0]          w_pop;
    logic [N_CH-1:0]          w_last;
    logic [N_CH-1:0][DW:0]    w_dout;
    logic [N_CH-1:0][DW-1:0]  w_data;
    logic [N_CH*DW-1:0]       w_join_data;
    logic [N_CH-1:0]          w_flush_pop;
    logic [N_CH-1:0]          w_held_nxt;
    logic                     w_avail;
    logic                     w_out_free;
    logic                     w_fire;
    logic                     w_all_last;
    logic                     w_any_last;
    logic                     w_in_flush;

    for (genvar i = 0; i < N_CH; i++) begin : g_ch
        axis_skid_fifo #(
            .WIDTH(DW + 1)
        ) u_fifo (
            .i_clk     (aclk),
            .i_rst_n   (aresetn),
            .i_wr_en   (w_push[i]),
            .i_wr_data ({s_axis_tlast[i], s_axis_tdata[i*DW +: DW]}),
            .i_rd_en   (w_pop[i]),
            .o_rd_data (w_dout[i]),
            .o_full    (w_full[i]),
            .o_empty   (w_empty[i])
        );

        assign w_last[i] = w_dout[i][DW];
        assign w_data[i] = w_dout[i][DW-1:0];

        // A channel that already delivered its tlast during a flush must not
        // leak the next packet's beats into the discard path.
        assign s_axis_tready[i] = r_mask[i] && !w_full[i] && !(w_in_flush && r_held[i]);
        assign w_push[i]        = s_axis_tvalid[i] && s_axis_tready[i];
        assign w_pop[i]         = (w_fire && r_mask[i]) || w_flush_pop[i];
        assign w_join_data[i*DW +: DW] = r_mask[i] ? w_data[i] : '0;
    end

    assign w_in_flush  = (r_state == ST_FLUSH);
    assign w_avail     = (r_mask != '0) && ((~w_empty | ~r_mask) == '1);
    assign w_out_free  = !r_tvalid || m_axis_tready;
    assign w_fire      = !w_in_flush && w_avail && w_out_free;
    assign w_all_last  = ((w_last & r_mask) == r_mask);
    assign w_any_last  = |(w_last & r_mask);
    assign w_flush_pop = w_in_flush ? (r_mask & ~r_held & ~w_empty) : '0;
    assign w_held_nxt  = r_held | (w_flush_pop & w_last);

    always_ff @(posedge aclk or negedge aresetn) begin
        if (!aresetn) begin
            r_state  <= ST_IDLE;
            r_mask   <= '0;
            r_held   <= '0;
            r_tvalid <= 1'b0;
            r_tlast  <= 1'b0;
            r_tdata  <= '0;
            r_err    <= 1'b0;
            r_count  <= '0;
        end else begin
            if (r_tvalid && m_axis_tready && r_tlast) r_count <= r_count + 1'b1;

            if (w_fire) begin
                r_tvalid <= 1'b1;
                r_tdata  <= w_join_data;
                r_tlast  <= w_any_last;
            end else if (m_axis_tready) begin
                r_tvalid <= 1'b0;
            end

            // The mask follows ch_enable only between packets; any join that opens
            // a packet (or a flush) freezes it.
            if (r_state == ST_IDLE && !(w_fire && !w_all_last)) r_mask <= ch_enable;

            case (r_state)
                ST_IDLE, ST_RUN: begin
                    if (w_fire) begin
                        if (w_all_last) begin
                            r_state <= ST_IDLE;
                        end else if (w_any_last) begin
                            r_state <= ST_FLUSH;
                            r_err   <= 1'b1;
                            r_held  <= w_last & r_mask;
                        end else begin
                            r_state <= ST_RUN;
                        end
                    end
                end
                ST_FLUSH: begin
                    if (w_held_nxt == r_mask) begin
                        r_state <= ST_IDLE;
                        r_held  <= '0;
                    end else begin
                        r_held  <= w_held_nxt;
                    end
                end
                default: r_state <= ST_IDLE;
            endcase
        end
    end

    assign m_axis_tvalid      = r_tvalid;
    assign m_axis_tlast       = r_tlast;
    assign m_axis_tdata       = r_tdata;
    assign err_tlast_mismatch = r_err;
    assign packet_count       = r_count;

endmodule

// File: tb/tb_axis_input_join.sv
// Scoreboard bench for axis_input_join: per-channel drive queues feed the DUT, joined beats are checked in order.
module tb_axis_input_join;

    localparam int N_CH  = 3;
    localparam int WW    = 8;
    localparam int WORDS = 4;
    localparam int CW    = 16;
    localparam int DW    = WW * WORDS;

    logic                aclk = 1'b0;
    logic                aresetn;
    logic [N_CH-1:0]     ch_enable;
    logic [N_CH*DW-1:0]  s_axis_tdata;
    logic [N_CH-1:0]     s_axis_tvalid;
    logic [N_CH-1:0]     s_axis_tready;
    logic [N_CH-1:0]     s_axis_tlast;
    logic [N_CH*DW-1:0]  m_axis_tdata;
    logic                m_axis_tvalid;
    logic                m_axis_tready;
    logic                m_axis_tlast;
    logic                err_tlast_mismatch;
    logic [CW-1:0]       packet_count;

    int errors = 0;
    int checks = 0;

    logic [DW:0]        drv_q [N_CH][$];
    logic [N_CH*DW:0]   exp_q [$];
    bit                 eng_on = 0;
    bit                 rand_v = 0;
    bit                 rand_r = 0;
    logic [N_CH-1:0]    pend = '0;
    bit                 prev_stall = 0;
    logic [N_CH*DW-1:0] hold_d;
    logic               hold_l;
    int nout = 0, mark = 0, first_cyc = 0, last_cyc = 0, cyc = 0;

    axis_input_join #(
        .N_CH(N_CH), .WORD_WIDTH(WW), .WORDS(WORDS), .CNT_WIDTH(CW)
    ) dut (
        .aclk               (aclk),
        .aresetn            (aresetn),
        .ch_enable          (ch_enable),
        .s_axis_tdata       (s_axis_tdata),
        .s_axis_tvalid      (s_axis_tvalid),
        .s_axis_tready      (s_axis_tready),
        .s_axis_tlast       (s_axis_tlast),
        .m_axis_tdata       (m_axis_tdata),
        .m_axis_tvalid      (m_axis_tvalid),
        .m_axis_tready      (m_axis_tready),
        .m_axis_tlast       (m_axis_tlast),
        .err_tlast_mismatch (err_tlast_mismatch),
        .packet_count       (packet_count)
    );

    always #5 aclk = ~aclk;
    always @(posedge aclk) cyc <= cyc + 1;

    initial begin
        #5_000_000;
        $display("FAIL watchdog: simulation time limit reached");
        $fatal(1);
    end

    function automatic logic [DW-1:0] word(input int tid, input int c, input int p, input int b);
        return {8'(tid), 8'(c), 8'(p), 8'(b)};
    endfunction

    // One cycle of bench activity: advance to the falling edge, then drive inputs and score outputs.
    task automatic step();
        logic [N_CH*DW:0] e;
        logic [DW:0]      d;
        @(negedge aclk);
        if (eng_on) begin
            for (int c = 0; c < N_CH; c++) begin
                if (pend[c]) void'(drv_q[c].pop_front());
                if (!(s_axis_tvalid[c] && !pend[c])) begin
                    if (drv_q[c].size() > 0 && (!rand_v || $urandom_range(0, 1) == 1)) begin
                        d = drv_q[c][0];
                        s_axis_tvalid[c]         = 1'b1;
                        s_axis_tdata[c*DW +: DW] = d[DW-1:0];
                        s_axis_tlast[c]          = d[DW];
                    end else begin
                        s_axis_tvalid[c] = 1'b0;
                    end
                end
            end
            pend = s_axis_tvalid & s_axis_tready;

            if (prev_stall) begin
                checks++;
                if (m_axis_tvalid !== 1'b1 || m_axis_tdata !== hold_d || m_axis_tlast !== hold_l) begin
                    errors++;
                    $display("FAIL stall_hold: got valid=%b last=%b data=%h, held last=%b data=%h",
                             m_axis_tvalid, m_axis_tlast, m_axis_tdata, hold_l, hold_d);
                end
            end
            m_axis_tready = rand_r ? ($urandom_range(0, 1) == 1) : 1'b1;
            if (m_axis_tvalid === 1'b1 && m_axis_tready === 1'b1) begin
                checks++;
                if (exp_q.size() == 0) begin
                    errors++;
                    $display("FAIL extra_beat: got last=%b data=%h, nothing expected", m_axis_tlast, m_axis_tdata);
                end else begin
                    e = exp_q.pop_front();
                    if ({m_axis_tlast, m_axis_tdata} !== e) begin
                        errors++;
                        $display("FAIL beat_%0d: got last=%b data=%h, expected last=%b data=%h",
                                 nout, m_axis_tlast, m_axis_tdata, e[N_CH*DW], e[N_CH*DW-1:0]);
                    end
                end
                if (nout == mark) first_cyc = cyc;
                last_cyc = cyc;
                nout++;
            end
            prev_stall = m_axis_tvalid && !m_axis_tready;
            hold_d     = m_axis_tdata;
            hold_l     = m_axis_tlast;
        end
    endtask

    task automatic eng_start(input bit rv, input bit rr);
        pend       = '0;
        prev_stall = 0;
        rand_v     = rv;
        rand_r     = rr;
        eng_on     = 1;
    endtask

    task automatic load_pkt(input int tid, input int p, input logic [N_CH-1:0] mask, input int len);
        logic [N_CH*DW-1:0] jd;
        for (int b = 1; b <= len; b++) begin
            jd = '0;
            for (int c = 0; c < N_CH; c++) begin
                if (mask[c]) begin
                    drv_q[c].push_back({(b == len), word(tid, c, p, b)});
                    jd[c*DW +: DW] = word(tid, c, p, b);
                end
            end
            exp_q.push_back({(b == len), jd});
        end
    endtask

    task automatic wait_drain(input int budget);
        int n = 0;
        while ((exp_q.size() != 0 || drv_q[0].size() != 0 || drv_q[1].size() != 0 ||
                drv_q[2].size() != 0) && n < budget) begin
            step();
            n++;
        end
        repeat (3) step();
    endtask

    task automatic test_reset();
        aresetn       = 1'b0;
        ch_enable     = 3'b111;
        s_axis_tvalid = '0;
        s_axis_tdata  = '0;
        s_axis_tlast  = '0;
        m_axis_tready = 1'b0;
        repeat (3) step();
        checks++; if (s_axis_tready !== '0) begin errors++; $display("FAIL rst_tready: got %b, expected 000", s_axis_tready); end
        checks++; if (m_axis_tvalid !== 1'b0) begin errors++; $display("FAIL rst_tvalid: got %b, expected 0", m_axis_tvalid); end
        checks++; if (m_axis_tlast !== 1'b0) begin errors++; $display("FAIL rst_tlast: got %b, expected 0", m_axis_tlast); end
        checks++; if (m_axis_tdata !== '0) begin errors++; $display("FAIL rst_tdata: got %h, expected 0", m_axis_tdata); end
        checks++; if (err_tlast_mismatch !== 1'b0) begin errors++; $display("FAIL rst_err: got %b, expected 0", err_tlast_mismatch); end
        checks++; if (packet_count !== '0) begin errors++; $display("FAIL rst_count: got %0d, expected 0", packet_count); end
        aresetn = 1'b1;
        repeat (3) step();
    endtask

    task automatic test_full_join();
        mark = nout;
        load_pkt(1, 0, 3'b111, 12);
        eng_start(0, 0);
        step();   // first beats presented, accepted at the next rising edge (k)
        step();
        checks++; if (m_axis_tvalid !== 1'b0) begin errors++; $display("FAIL latency_k: tvalid=%b after edge k, expected 0", m_axis_tvalid); end
        step();
        checks++; if (m_axis_tvalid !== 1'b1) begin errors++; $display("FAIL latency_k1: tvalid=%b after edge k+1, expected 1", m_axis_tvalid); end
        wait_drain(100);
        checks++; if (exp_q.size() != 0) begin errors++; $display("FAIL full_lost: %0d beats missing, expected 0", exp_q.size()); end
        checks++; if (packet_count !== 16'd1) begin errors++; $display("FAIL full_count: got %0d, expected 1", packet_count); end
        checks++; if (last_cyc - first_cyc != 11) begin errors++; $display("FAIL throughput: 12 beats spanned %0d cycles, expected 11", last_cyc - first_cyc); end
    endtask

    task automatic test_mask_101();
        ch_enable = 3'b101;
        repeat (2) step();
        load_pkt(2, 0, 3'b101, 8);
        step();
        checks++; if (s_axis_tready[1] !== 1'b0) begin errors++; $display("FAIL mask_tready1: got %b, expected 0", s_axis_tready[1]); end
        wait_drain(100);
        checks++; if (exp_q.size() != 0) begin errors++; $display("FAIL mask_lost: %0d beats missing, expected 0", exp_q.size()); end
        checks++; if (packet_count !== 16'd2) begin errors++; $display("FAIL mask_count: got %0d, expected 2", packet_count); end
    endtask

    task automatic test_zero_mask();
        eng_on    = 0;
        ch_enable = 3'b000;
        repeat (2) step();
        s_axis_tvalid = 3'b111;
        s_axis_tlast  = 3'b111;
        repeat (4) step();
        checks++; if (s_axis_tready !== 3'b000) begin errors++; $display("FAIL zero_tready: got %b, expected 000", s_axis_tready); end
        checks++; if (m_axis_tvalid !== 1'b0) begin errors++; $display("FAIL zero_tvalid: got %b, expected 0", m_axis_tvalid); end
        s_axis_tvalid = '0;
        ch_enable     = 3'b111;
        repeat (2) step();
    endtask

    task automatic test_random_stall();
        int lens[5] = '{3, 1, 7, 5, 8};
        eng_start(1, 1);
        for (int p = 0; p < 5; p++) load_pkt(3, p, 3'b111, lens[p]);
        wait_drain(2000);
        checks++; if (exp_q.size() != 0) begin errors++; $display("FAIL rand_lost: %0d beats missing, expected 0", exp_q.size()); end
        checks++; if (packet_count !== 16'd7) begin errors++; $display("FAIL rand_count: got %0d, expected 7", packet_count); end
    endtask

    task automatic test_tlast_mismatch();
        logic [N_CH*DW-1:0] jd;
        eng_start(0, 0);
        for (int b = 1; b <= 6; b++) begin
            drv_q[0].push_back({(b == 6), word(5, 0, 0, b)});
            drv_q[1].push_back({(b == 6), word(5, 1, 0, b)});
        end
        for (int b = 1; b <= 4; b++) begin
            drv_q[2].push_back({(b == 4), word(5, 2, 0, b)});
            jd = {word(5, 2, 0, b), word(5, 1, 0, b), word(5, 0, 0, b)};
            exp_q.push_back({(b == 4), jd});
        end
        load_pkt(5, 1, 3'b111, 3);
        wait_drain(300);
        checks++; if (exp_q.size() != 0) begin errors++; $display("FAIL mis_lost: %0d beats missing, expected 0", exp_q.size()); end
        checks++; if (err_tlast_mismatch !== 1'b1) begin errors++; $display("FAIL mis_err: got %b, expected 1", err_tlast_mismatch); end
        checks++; if (packet_count !== 16'd9) begin errors++; $display("FAIL mis_count: got %0d, expected 9", packet_count); end
        checks++; if (s_axis_tready !== 3'b111) begin errors++; $display("FAIL mis_idle_tready: got %b, expected 111", s_axis_tready); end
    endtask

    task automatic test_reset_mid();
        int n = 0;
        eng_start(0, 0);
        mark = nout;
        load_pkt(6, 0, 3'b111, 12);
        while (nout < mark + 3 && n < 50) begin
            step();
            n++;
        end
        checks++; if (nout < mark + 3) begin errors++; $display("FAIL rmid_timeout: got %0d beats, expected 3", nout - mark); end
        eng_on = 0;
        @(posedge aclk);
        #2;
        aresetn = 1'b0;
        #1;
        checks++; if (m_axis_tvalid !== 1'b0) begin errors++; $display("FAIL rmid_tvalid: got %b, expected 0", m_axis_tvalid); end
        checks++; if (m_axis_tlast !== 1'b0) begin errors++; $display("FAIL rmid_tlast: got %b, expected 0", m_axis_tlast); end
        checks++; if (m_axis_tdata !== '0) begin errors++; $display("FAIL rmid_tdata: got %h, expected 0", m_axis_tdata); end
        checks++; if (s_axis_tready !== 3'b000) begin errors++; $display("FAIL rmid_tready: got %b, expected 000", s_axis_tready); end
        checks++; if (err_tlast_mismatch !== 1'b0) begin errors++; $display("FAIL rmid_err: got %b, expected 0", err_tlast_mismatch); end
        checks++; if (packet_count !== '0) begin errors++; $display("FAIL rmid_count: got %0d, expected 0", packet_count); end
        exp_q.delete();
        for (int c = 0; c < N_CH; c++) drv_q[c].delete();
        s_axis_tvalid = '0;
        repeat (2) step();
        aresetn = 1'b1;
        repeat (2) step();
        eng_start(0, 0);
        load_pkt(7, 0, 3'b111, 2);
        wait_drain(100);
        checks++; if (exp_q.size() != 0) begin errors++; $display("FAIL rmid_lost: %0d beats missing, expected 0", exp_q.size()); end
        checks++; if (packet_count !== 16'd1) begin errors++; $display("FAIL rmid_fresh_count: got %0d, expected 1", packet_count); end
    endtask

    task automatic test_wrap();
        int sent = 0;
        int guard = 0;
        eng_on = 0;
        s_axis_tvalid = '0;
        aresetn = 1'b0;
        step();
        aresetn = 1'b1;
        repeat (2) step();
        s_axis_tdata  = '0;
        s_axis_tlast  = 3'b111;
        m_axis_tready = 1'b1;
        while (sent < 65537 && guard < 70000) begin
            step();
            s_axis_tvalid = 3'b111;
            if (&s_axis_tready) sent++;
            guard++;
        end
        step();
        s_axis_tvalid = '0;
        repeat (5) step();
        checks++; if (sent != 65537) begin errors++; $display("FAIL wrap_timeout: sent %0d packets, expected 65537", sent); end
        checks++; if (packet_count !== 16'd1) begin errors++; $display("FAIL wrap_count: got %0d, expected 1", packet_count); end
        checks++; if (m_axis_tvalid !== 1'b0) begin errors++; $display("FAIL wrap_idle: tvalid=%b, expected 0", m_axis_tvalid); end
    endtask

    initial begin
        test_reset();
        test_full_join();
        test_mask_101();
        test_zero_mask();
        test_random_stall();
        test_tlast_mismatch();
        test_reset_mid();
        test_wrap();
        $display("Result: errors=%0d of %0d checks", errors, checks);
        $finish;
    end

endmodule
